// File: rtl/accel_buffer_pkg.sv
// rtl/accel_buffer_pkg.sv - shared constants and read-FSM encoding for the sample ping-pong buffer
//
// Purpose: bank geometry, acknowledge timeout and read-side state encoding
//          shared by sample_pingpong_buffer and sample_bank_ram.
// Ports:   none (package).

package accel_buffer_pkg;

    localparam int BANK_DEPTH    = 16;
    localparam int PTR_BITS      = 4;
    localparam int WAIT_TIMEOUT  = 32;

    // One extra address bit selects the bank.
    localparam int ADDR_BITS     = PTR_BITS + 1;
    localparam int WAIT_CNT_BITS = $clog2(WAIT_TIMEOUT);

    localparam logic [PTR_BITS-1:0]      PTR_LAST  = PTR_BITS'(BANK_DEPTH - 1);
    localparam logic [WAIT_CNT_BITS-1:0] WAIT_LAST = WAIT_CNT_BITS'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_DRAIN    = 2'd1,
        RD_WAIT_AVG = 2'd2,
        RD_GAP      = 2'd3
    } rd_state_t;

    // Flat RAM address: bank bit on top, word pointer below.
    function automatic logic [ADDR_BITS-1:0] bank_addr(input logic bank,
                                                        input logic [PTR_BITS-1:0] ptr);
        return {bank, ptr};
    endfunction

endpackage

// File: rtl/sample_bank_ram.sv
// rtl/sample_bank_ram.sv - two-bank sample storage, one write port, one registered read port
//
// Purpose: 32 x DATA_WIDTH storage holding both ping-pong banks.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset, clears only the read register
//   wr_en    - write strobe
//   wr_addr  - write address {bank, word}
//   wr_data  - write data
//   rd_en    - read strobe; rd_data holds its value while low
//   rd_addr  - read address {bank, word}
//   rd_data  - registered read data

module sample_bank_ram
    import accel_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH_BITS = ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_BITS-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_BITS-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_BITS) - 1];

    // Storage is intentionally left out of reset so it maps onto a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_pingpong_buffer.sv
// rtl/sample_pingpong_buffer.sv - ping-pong buffer between SPI sampler and burst averager
//
// Purpose: collects 16-sample blocks into alternating banks and replays each
//          full bank as a 16-cycle burst to the averager, then waits for its
//          completion pulse (or a timeout) and a one-cycle idle gap.
// Ports:
//   clk             - rising-edge clock
//   reset           - asynchronous active-low reset
//   i_SPI_Data      - incoming sample, captured when i_SPI_Valid is high
//   i_SPI_Valid     - one-cycle sample strobe
//   i_AVG_Ready     - averager "average complete" pulse, honoured in WAIT_AVG only
//   o_MEM_Data      - sample presented to the averager
//   o_MEM_AddSignal - o_MEM_Data is valid for accumulation this cycle
//   o_MEM_Busy      - read FSM is not idle
//   o_MEM_Overflow  - sticky: a sample was dropped because its bank was full
//   o_MEM_Timeout   - sticky: the averager failed to acknowledge a burst in time

module sample_pingpong_buffer
    import accel_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_SPI_Data,
    input  logic                  i_SPI_Valid,
    input  logic                  i_AVG_Ready,
    output logic [DATA_WIDTH-1:0] o_MEM_Data,
    output logic                  o_MEM_AddSignal,
    output logic                  o_MEM_Busy,
    output logic                  o_MEM_Overflow,
    output logic                  o_MEM_Timeout
);

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [PTR_BITS-1:0] wr_ptr;
    logic                wr_bank;
    logic [1:0]          bank_full;
    logic [1:0]          full_next;
    logic                wr_accept;
    logic                wr_last;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t                state;
    rd_state_t                state_next;
    logic                     rd_bank;
    logic [PTR_BITS-1:0]      rd_ptr;
    logic [PTR_BITS-1:0]      rd_ptr_next;
    logic [WAIT_CNT_BITS-1:0] wait_cnt;
    logic [WAIT_CNT_BITS-1:0] wait_cnt_next;
    logic                     rd_en;
    logic                     rd_release;
    logic                     timeout_hit;

    // A sample is only ever written into a non-full bank, so the bank being
    // drained (always full) can never be overwritten.
    always_comb begin
        wr_accept = i_SPI_Valid && !bank_full[wr_bank];
        wr_last   = wr_accept && (wr_ptr == PTR_LAST);
        full_next = bank_full;
        // Release and fill always target different banks: the read bank is
        // full and the write bank is not, so both can happen on one edge.
        if (rd_release) begin
            full_next[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            wr_bank        <= 1'b0;
            bank_full      <= 2'b00;
            o_MEM_Overflow <= 1'b0;
        end else begin
            bank_full <= full_next;
            if (wr_accept) begin
                wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (i_SPI_Valid && bank_full[wr_bank]) begin
                o_MEM_Overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM. Word 0 is read on the IDLE->DRAIN edge and words 1..15 on
    // the following DRAIN edges, so the registered AddSignal spans exactly
    // 16 cycles. rd_ptr is back at 0 whenever the FSM is idle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        rd_ptr_next   = rd_ptr;
        wait_cnt_next = wait_cnt;
        rd_en         = 1'b0;
        rd_release    = 1'b0;
        timeout_hit   = 1'b0;

        case (state)
            RD_IDLE: begin
                if (bank_full[rd_bank]) begin
                    rd_en       = 1'b1;
                    rd_ptr_next = rd_ptr + 1'b1;
                    state_next  = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                rd_en       = 1'b1;
                rd_ptr_next = rd_ptr + 1'b1;
                if (rd_ptr == PTR_LAST) begin
                    rd_release    = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = RD_WAIT_AVG;
                end
            end
            RD_WAIT_AVG: begin
                if (i_AVG_Ready) begin
                    wait_cnt_next = '0;
                    state_next    = RD_GAP;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit   = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = RD_GAP;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            RD_GAP: begin
                // One guaranteed idle cycle so the averager can clear its sum.
                state_next = RD_IDLE;
            end
            default: begin
                state_next = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= RD_IDLE;
            rd_ptr          <= '0;
            rd_bank         <= 1'b0;
            wait_cnt        <= '0;
            o_MEM_AddSignal <= 1'b0;
            o_MEM_Busy      <= 1'b0;
            o_MEM_Timeout   <= 1'b0;
        end else begin
            state           <= state_next;
            rd_ptr          <= rd_ptr_next;
            wait_cnt        <= wait_cnt_next;
            o_MEM_AddSignal <= rd_en;
            o_MEM_Busy      <= (state_next != RD_IDLE);
            if (rd_release) begin
                rd_bank <= ~rd_bank;
            end
            if (timeout_hit) begin
                o_MEM_Timeout <= 1'b1;
            end
        end
    end

    // The RAM read register is the o_MEM_Data register: it only loads while
    // a burst word is being fetched, so the output holds between bursts.
    sample_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_BITS (ADDR_BITS)
    ) u_bank_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (bank_addr(wr_bank, wr_ptr)),
        .wr_data (i_SPI_Data),
        .rd_en   (rd_en),
        .rd_addr (bank_addr(rd_bank, rd_ptr)),
        .rd_data (o_MEM_Data)
    );

endmodule
